// File: rtl/payload_char_decoder.sv
// Serialises an AXI4-Stream payload to one byte per clock and drives the shared
// character-class lines (cls/en/sod/eod) consumed by the payload engines.
module payload_char_decoder #(
  parameter int DATA_WIDTH  = 64,
  parameter int NUM_CLASSES = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  input  logic                      cfg_wr_en,
  input  logic [7:0]                cfg_addr,
  input  logic [NUM_CLASSES-1:0]    cfg_wr_data,
  output logic                      sod,
  output logic                      en,
  output logic [NUM_CLASSES-1:0]    cls,
  output logic [7:0]                byte_out,
  output logic                      eod
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int IW     = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;
  localparam int CW     = $clog2(KEEP_W + 1);

  // Handshake: a word transfers on a rising edge where s_axis_tvalid and
  // s_axis_tready are both high; tready never depends on tvalid.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SOD    = 2'd1,
    STREAM = 2'd2,
    EOD    = 2'd3
  } state_t;

  state_t state, state_n;

  logic [NUM_CLASSES-1:0] class_table [256];

  logic [DATA_WIDTH-1:0] word_q;
  logic                  word_full;
  logic                  word_last;
  logic [CW-1:0]         word_nbytes;
  logic [IW-1:0]         idx, idx_n;

  logic          tready_c;
  logic          sod_c;
  logic          issue;
  logic          load;
  logic          clear_word;
  logic [CW-1:0] in_nbytes;
  logic [CW-1:0] load_nbytes;
  logic          keep_run;
  logic          at_final;
  logic [7:0]    cur_byte;

  // Valid bytes of a last word: the unbroken run of 1s in tkeep from bit 0.
  always_comb begin
    in_nbytes = '0;
    keep_run  = 1'b1;
    for (int i = 0; i < KEEP_W; i++) begin
      if (keep_run && s_axis_tkeep[i]) begin
        in_nbytes = in_nbytes + CW'(1);
      end else begin
        keep_run = 1'b0;
      end
    end
  end

  assign load_nbytes = s_axis_tlast ? in_nbytes : CW'(KEEP_W);
  assign at_final    = ((CW'(idx) + CW'(1)) == word_nbytes);
  assign cur_byte    = word_q[{idx, 3'b000} +: 8];

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    tready_c   = 1'b0;
    sod_c      = 1'b0;
    issue      = 1'b0;
    load       = 1'b0;
    clear_word = 1'b0;
    case (state)
      IDLE: begin
        if (s_axis_tvalid) state_n = SOD;
      end
      SOD: begin
        sod_c    = 1'b1;
        tready_c = 1'b1;
        if (s_axis_tvalid) begin
          // An empty last word skips STREAM so eod lands two cycles after sod.
          if (s_axis_tlast && (in_nbytes == '0)) begin
            state_n = EOD;
          end else begin
            load    = 1'b1;
            state_n = STREAM;
          end
        end
      end
      STREAM: begin
        if (word_full) begin
          if (word_nbytes == '0) begin
            clear_word = 1'b1;
            state_n    = EOD;
          end else begin
            issue = 1'b1;
            if (at_final) begin
              if (word_last) begin
                clear_word = 1'b1;
                state_n    = EOD;
              end else begin
                tready_c = 1'b1;
                if (s_axis_tvalid) load = 1'b1;
                else               clear_word = 1'b1;
              end
            end else begin
              idx_n = idx + IW'(1);
            end
          end
        end else begin
          tready_c = 1'b1;
          if (s_axis_tvalid) load = 1'b1;
        end
      end
      EOD: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (load) idx_n = '0;
  end

  assign s_axis_tready = tready_c & ~rst;
  assign sod           = sod_c & ~rst;

  // Table has no reset so a packet-level rst never loses the programming.
  always_ff @(posedge clk) begin
    if (cfg_wr_en) class_table[cfg_addr] <= cfg_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      word_q      <= '0;
      word_full   <= 1'b0;
      word_last   <= 1'b0;
      word_nbytes <= '0;
      en          <= 1'b0;
      cls         <= '0;
      byte_out    <= '0;
      eod         <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (load) begin
        word_q      <= s_axis_tdata;
        word_last   <= s_axis_tlast;
        word_nbytes <= load_nbytes;
        word_full   <= 1'b1;
      end else if (clear_word) begin
        word_full <= 1'b0;
      end
      en  <= issue;
      cls <= issue ? class_table[cur_byte] : '0;
      if (issue) byte_out <= cur_byte;
      // Registered from the EOD state so eod trails the final en by one cycle.
      eod <= (state == EOD);
    end
  end

endmodule

// File: tb/tb_payload_char_decoder.sv
// Directed bench for payload_char_decoder: drives packets, logs sod/en/eod
// activity per cycle and checks bytes, classes and timing against hand values.
module tb_payload_char_decoder;

  localparam int DW = 64;
  localparam int NC = 33;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          cfg_wr_en;
  logic [7:0]    cfg_addr;
  logic [NC-1:0] cfg_wr_data;
  logic          sod;
  logic          en;
  logic [NC-1:0] cls;
  logic [7:0]    byte_out;
  logic          eod;

  payload_char_decoder #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data),
    .sod(sod), .en(en), .cls(cls), .byte_out(byte_out), .eod(eod)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // observed activity log
  int            sod_q[$];
  int            eod_q[$];
  int            en_c[$];
  logic [7:0]    byte_q[$];
  logic [NC-1:0] cls_q[$];
  int            tr_cnt = 0;
  int            overlap = 0;

  // scoreboard: expected bytes and table model
  logic [7:0]    exp_q[$];
  logic [NC-1:0] tbl_m [256];

  always @(negedge clk) begin
    if (sod) sod_q.push_back(cyc);
    if (eod) eod_q.push_back(cyc);
    if (sod && eod) overlap++;
    if (s_axis_tready) tr_cnt++;
    if (en) begin
      en_c.push_back(cyc);
      byte_q.push_back(byte_out);
      cls_q.push_back(cls);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    sod_q.delete(); eod_q.delete(); en_c.delete();
    byte_q.delete(); cls_q.delete(); exp_q.delete();
    tr_cnt = 0;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [NC-1:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wr_data = d;
    tbl_m[a] = d;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  // Presents one beat and holds it until accepted; tvalid is left high.
  task automatic send_beat(input string tag, input logic [DW-1:0] d,
                           input logic [KW-1:0] k, input logic l);
    bit hs;
    int n;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    hs = 1'b0;
    n = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_accept"}, 64'(hs), 64'd1);
  endtask

  task automatic drop_valid();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tkeep = '0;
  endtask

  task automatic push_bytes(input logic [DW-1:0] d, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(d[i*8 +: 8]);
  endtask

  // One packet: single sod, en stream from sod+2 (with an optional bubble of
  // 'gap' cycles before byte gap_at), eod one cycle after the final en.
  task automatic check_stream(input string tag, input int gap_at, input int gap);
    int n;
    int ecyc;
    n = exp_q.size();
    chk({tag, "_sod_n"}, 64'(sod_q.size()), 64'd1);
    chk({tag, "_en_n"},  64'(en_c.size()),  64'(n));
    chk({tag, "_eod_n"}, 64'(eod_q.size()), 64'd1);
    for (int i = 0; i < n && i < en_c.size(); i++) begin
      ecyc = sod_q[0] + 2 + i + ((i >= gap_at) ? gap : 0);
      chk($sformatf("%s_en_cyc%0d", tag, i), 64'(en_c[i]), 64'(ecyc));
      chk($sformatf("%s_byte%0d", tag, i), 64'(byte_q[i]), 64'(exp_q[i]));
      chk($sformatf("%s_cls%0d", tag, i), 64'(cls_q[i]), 64'(tbl_m[exp_q[i]]));
    end
    if (n == 0) ecyc = sod_q[0] + 2;
    else ecyc = sod_q[0] + 2 + (n - 1) + ((n - 1 >= gap_at) ? gap : 0) + 1;
    chk({tag, "_eod_cyc"}, 64'(eod_q[0]), 64'(ecyc));
  endtask

  logic [DW-1:0] w;
  bit            hs;
  int            n;
  int            s0;

  initial begin
    for (int i = 0; i < 256; i++) tbl_m[i] = '0;
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_sod", 64'(sod), 64'd0);
    chk("rst_en", 64'(en), 64'd0);
    chk("rst_eod", 64'(eod), 64'd0);
    chk("rst_cls", 64'(cls), 64'd0);
    chk("rst_byte", 64'(byte_out), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);

    // 1: "new java" with space and n/N classes
    cfg_write(8'h20, NC'(1) << 8);
    cfg_write(8'h4E, NC'(1) << 3);
    cfg_write(8'h6E, NC'(1) << 3);
    clear_log();
    w = 64'h6176_616A_2077_656E;
    push_bytes(w, 8);
    send_beat("t1", w, 8'hFF, 1'b1);
    drop_valid();
    repeat (15) @(posedge clk); #1;
    check_stream("t1", 1000, 0);
    chk("t1_cls_space", 64'(cls_q[3]), 64'(NC'(1) << 8));
    chk("t1_cls_n", 64'(cls_q[0]), 64'(NC'(1) << 3));

    // 2: three words with tvalid held high
    cfg_write(8'h05, NC'(1) << 1);
    cfg_write(8'h12, NC'(1) << 32);
    clear_log();
    w = 64'h0706_0504_0302_0100; push_bytes(w, 8); send_beat("t2w0", w, 8'hFF, 1'b0);
    w = 64'h0F0E_0D0C_0B0A_0908; push_bytes(w, 8); send_beat("t2w1", w, 8'hFF, 1'b0);
    w = 64'h1716_1514_1312_1110; push_bytes(w, 8); send_beat("t2w2", w, 8'hFF, 1'b1);
    drop_valid();
    repeat (15) @(posedge clk); #1;
    check_stream("t2", 1000, 0);
    chk("t2_tready_cycles", 64'(tr_cnt), 64'd3);

    // 3a: tkeep 0x07 -> 3 bytes
    clear_log();
    w = 64'h8877_6655_4433_2211; push_bytes(w, 3);
    send_beat("t3a", w, 8'h07, 1'b1);
    drop_valid();
    repeat (12) @(posedge clk); #1;
    check_stream("t3a", 1000, 0);

    // 3b: tkeep 0x0B -> run of 1s from bit 0 is 2 bytes
    clear_log();
    w = 64'h8877_6655_4433_2211; push_bytes(w, 2);
    send_beat("t3b", w, 8'h0B, 1'b1);
    drop_valid();
    repeat (12) @(posedge clk); #1;
    check_stream("t3b", 1000, 0);

    // 3c: tkeep 0x17 -> 3 bytes, byte 4 dropped
    clear_log();
    w = 64'h4E20_6E55_4433_2211; push_bytes(w, 3);
    send_beat("t3c", w, 8'h17, 1'b1);
    drop_valid();
    repeat (12) @(posedge clk); #1;
    check_stream("t3c", 1000, 0);

    // 4: tvalid low for 5 cycles from the point the block is ready
    clear_log();
    w = 64'hA7A6_A5A4_A3A2_A1A0; push_bytes(w, 8);
    send_beat("t4w0", w, 8'hFF, 1'b0);
    drop_valid();
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = s_axis_tready;
      if (!hs) begin @(posedge clk); #1; end
      n++;
    end
    chk("t4_ready_wait", 64'(hs), 64'd1);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    w = 64'h4E20_B5B4_B3B2_B1B0; push_bytes(w, 8);
    send_beat("t4w1", w, 8'hFF, 1'b1);
    drop_valid();
    repeat (15) @(posedge clk); #1;
    check_stream("t4", 8, 5);

    // 5: empty packet, then a 1-byte packet back to back
    clear_log();
    send_beat("t5e", 64'h0, 8'h00, 1'b1);
    send_beat("t5b", 64'h20, 8'h01, 1'b1);
    drop_valid();
    repeat (15) @(posedge clk); #1;
    chk("t5_sod_n", 64'(sod_q.size()), 64'd2);
    chk("t5_eod_n", 64'(eod_q.size()), 64'd2);
    chk("t5_en_n", 64'(en_c.size()), 64'd1);
    chk("t5_empty_eod", 64'(eod_q[0]), 64'(sod_q[0] + 2));
    chk("t5_sod_after_eod", 64'(sod_q[1] > eod_q[0]), 64'd1);
    chk("t5_en_cyc", 64'(en_c[0]), 64'(sod_q[1] + 2));
    chk("t5_byte", 64'(byte_q[0]), 64'h20);
    chk("t5_cls", 64'(cls_q[0]), 64'(NC'(1) << 8));
    chk("t5_eod2", 64'(eod_q[1]), 64'(en_c[0] + 1));

    // 6: rst while the 4th byte is being issued
    clear_log();
    send_beat("t6", 64'h6E6E_6E6E_6E6E_6E6E, 8'hFF, 1'b1);
    drop_valid();
    s0 = (sod_q.size() > 0) ? sod_q[0] : -100;
    chk("t6_sod_seen", 64'(sod_q.size()), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_en", 64'(en), 64'd0);
    chk("t6_rst_sod", 64'(sod), 64'd0);
    chk("t6_rst_eod", 64'(eod), 64'd0);
    chk("t6_rst_cls", 64'(cls), 64'd0);
    chk("t6_rst_byte", 64'(byte_out), 64'd0);
    rst = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk("t6_en_n", 64'(en_c.size()), 64'd3);
    chk("t6_last_en_cyc", 64'(en_c[2]), 64'(s0 + 4));
    chk("t6_eod_n", 64'(eod_q.size()), 64'd0);
    chk("t6_sod_n", 64'(sod_q.size()), 64'd1);
    chk("t6_table_kept", 64'(cls_q[0]), 64'(NC'(1) << 3));

    clear_log();
    w = 64'h6176_616A_2077_656E; push_bytes(w, 8);
    send_beat("t6n", w, 8'hFF, 1'b1);
    drop_valid();
    repeat (15) @(posedge clk); #1;
    check_stream("t6n", 1000, 0);

    chk("sod_eod_overlap", 64'(overlap), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
